// File: rtl/player_ctrl.sv
// player_ctrl: sequencing controller for the music player.
// Turns play/next button pulses and song_done into play, song and
// reset_player controls for song_reader. Moore FSM: every output decodes
// from registers only, so no input reaches an output combinationally.
module player_ctrl #(
  parameter int NUM_SONGS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_button,
  input  logic       next_button,
  input  logic       loop_en,
  input  logic       song_done,
  output logic       play,
  output logic [1:0] song,
  output logic       reset_player,
  output logic [1:0] state
);

  // Encoding doubles as the externally visible status code.
  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_PAUSE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_NEXT  = 2'b11
  } state_t;

  localparam logic [1:0] LAST_SONG = 2'(NUM_SONGS - 1);

  state_t     state_q, state_d;
  logic [1:0] song_q, song_d;
  logic       resume_q, resume_d;
  logic       last_song;

  // State, song index and resume flag registers; reset dominates all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RESET;
      song_q   <= 2'd0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      resume_q <= resume_d;
    end
  end

  // Next-state logic with per-state input priorities.
  always_comb begin
    state_d   = state_q;
    song_d    = song_q;
    resume_d  = resume_q;
    last_song = (song_q == LAST_SONG);
    case (state_q)
      ST_RESET: begin
        // Inputs ignored; clear the playlist position and settle in PAUSE.
        song_d   = 2'd0;
        resume_d = 1'b0;
        state_d  = ST_PAUSE;
      end
      ST_PAUSE: begin
        // song_done is ignored while paused.
        if (next_button) begin
          resume_d = 1'b0;
          state_d  = ST_NEXT;
        end else if (play_button) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (next_button) begin
          resume_d = 1'b1;
          state_d  = ST_NEXT;
        end else if (song_done) begin
          if (!last_song || loop_en) begin
            // Wrap to song 0 happens on the NEXT exit increment.
            resume_d = 1'b1;
            state_d  = ST_NEXT;
          end else begin
            // End of playlist without looping: restart stopped at song 0.
            state_d = ST_RESET;
          end
        end else if (play_button) begin
          state_d = ST_PAUSE;
        end
      end
      ST_NEXT: begin
        // One-cycle pulse; song still shows the old index during it.
        song_d  = last_song ? 2'd0 : song_q + 2'd1;
        state_d = resume_q ? ST_PLAY : ST_PAUSE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign play         = (state_q == ST_PLAY);
  assign reset_player = (state_q == ST_RESET) || (state_q == ST_NEXT);
  assign state        = state_q;
  assign song         = song_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed scenarios with literal
// expectations, then randomized button/song_done traffic checked every
// cycle against a behavioural model. Two instances: 4 songs and 1 song.
module tb_player_ctrl;

  logic       clk;
  logic       reset;
  logic       play_button;
  logic       next_button;
  logic       loop_en;
  logic       song_done;

  logic       a_play, a_rp, b_play, b_rp;
  logic [1:0] a_song, a_state, b_song, b_state;

  int n_checks = 0;
  int n_fail   = 0;

  player_ctrl #(.NUM_SONGS(4)) dut_a (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .loop_en(loop_en), .song_done(song_done),
    .play(a_play), .song(a_song), .reset_player(a_rp), .state(a_state)
  );

  player_ctrl #(.NUM_SONGS(1)) dut_b (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .loop_en(loop_en), .song_done(song_done),
    .play(b_play), .song(b_song), .reset_player(b_rp), .state(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0=reset,1=paused,2=playing,3=skipping.
  typedef struct {
    int st;
    int sg;
    bit rs;
    bit dc;   // song index not pinned this cycle (internal restart cycle)
    bit ok;   // model synchronised by a reset
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(input mdl_t s, input bit r, input bit p,
                                 input bit n, input bit d, input bit l,
                                 input int ns);
    mdl_t o;
    o    = s;
    o.dc = 1'b0;
    if (r) begin
      o.st = 0; o.sg = 0; o.rs = 1'b0; o.ok = 1'b1;
      return o;
    end
    if (!s.ok) return o;
    case (s.st)
      0: begin o.st = 1; o.sg = 0; o.rs = 1'b0; end
      1: begin
        if (n) begin o.st = 3; o.rs = 1'b0; end
        else if (p) o.st = 2;
      end
      2: begin
        if (n) begin o.st = 3; o.rs = 1'b1; end
        else if (d) begin
          if ((s.sg != ns - 1) || l) begin o.st = 3; o.rs = 1'b1; end
          else begin o.st = 0; o.dc = 1'b1; end
        end
        else if (p) o.st = 1;
      end
      default: begin
        o.sg = (s.sg + 1) % ns;
        o.st = s.rs ? 2 : 1;
      end
    endcase
    return o;
  endfunction

  // Advance both models on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    ma <= mstep(ma, reset, play_button, next_button, song_done, loop_en, 4);
    mb <= mstep(mb, reset, play_button, next_button, song_done, loop_en, 1);
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ma.ok) begin
      cmp("A.state", int'(a_state), ma.st);
      cmp("A.play", int'(a_play), int'(ma.st == 2));
      cmp("A.reset_player", int'(a_rp), int'(ma.st == 0 || ma.st == 3));
      if (!ma.dc) cmp("A.song", int'(a_song), ma.sg);
    end
    if (mb.ok) begin
      cmp("B.state", int'(b_state), mb.st);
      cmp("B.play", int'(b_play), int'(mb.st == 2));
      cmp("B.reset_player", int'(b_rp), int'(mb.st == 0 || mb.st == 3));
      if (!mb.dc) cmp("B.song", int'(b_song), mb.sg);
    end
  end

  // Apply inputs for one edge, then clear the pulses just after it.
  task automatic drive(input bit r, input bit p, input bit n, input bit d,
                       input bit l);
    reset       = r;
    play_button = p;
    next_button = n;
    song_done   = d;
    loop_en     = l;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
  endtask

  // Literal expectation on the 4-song instance, one line per transaction.
  task automatic lit(input string nm, input int st, input int pl,
                     input int sg, input int rp);
    $display("step %s: state=%0d play=%0d song=%0d reset_player=%0d",
             nm, a_state, a_play, a_song, a_rp);
    cmp({nm, ".state"}, int'(a_state), st);
    cmp({nm, ".play"}, int'(a_play), pl);
    cmp({nm, ".song"}, int'(a_song), sg);
    cmp({nm, ".reset_player"}, int'(a_rp), rp);
  endtask

  // From PLAY, skip forward one song (NEXT then PLAY).
  task automatic skip_one();
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; play_button = 1'b0; next_button = 1'b0;
    song_done = 1'b0; loop_en = 1'b0;

    // Reset held three cycles, then one more RESET cycle, then PAUSE.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      lit("reset_hold", 0, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0);
    lit("reset_release", 1, 0, 0, 0);

    // Play then pause five cycles later.
    drive(0, 1, 0, 0, 0);
    lit("play_press", 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
    lit("playing", 2, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    lit("pause_press", 1, 0, 0, 0);

    // Skip while playing from song 1.
    drive(0, 1, 0, 0, 0);
    skip_one();
    lit("at_song1", 2, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    lit("skip_next", 3, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    lit("skip_done", 2, 1, 2, 0);

    // End of playlist without loop: restart stopped at song 0.
    skip_one();
    lit("at_song3", 2, 1, 3, 0);
    drive(0, 0, 0, 1, 0);
    lit("end_noloop", 0, 0, 3, 1);
    drive(0, 0, 0, 0, 0);
    lit("end_noloop_pause", 1, 0, 0, 0);

    // End of playlist with loop: wrap to song 0 and keep playing.
    drive(0, 1, 0, 0, 1);
    skip_one(); skip_one(); skip_one();
    drive(0, 0, 0, 1, 1);
    lit("end_loop", 3, 0, 3, 1);
    drive(0, 0, 0, 0, 1);
    lit("end_loop_play", 2, 1, 0, 0);

    // next+play together in PAUSE: next wins, stays paused.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    lit("both_pause", 3, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    lit("both_pause_done", 1, 0, 1, 0);

    // song_done+play together in PLAY with song 0: advance and keep playing.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    lit("done_play", 3, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    lit("done_play_done", 2, 1, 1, 0);

    // Reset during NEXT with song 2 and resume set.
    skip_one();
    drive(0, 0, 1, 0, 0);
    lit("next_s2", 3, 0, 2, 1);
    drive(1, 0, 0, 0, 0);
    lit("mid_reset", 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    lit("mid_reset_pause", 1, 0, 0, 0);

    // Randomized traffic checked by the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 99) == 0),
            bit'($urandom_range(0, 5) == 0),
            bit'($urandom_range(0, 7) == 0),
            bit'($urandom_range(0, 6) == 0),
            bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Top-level sequencing controller for the music player. Converts one-cycle `play_button` and `next_button` pulses into the `play`, `song` and `reset_player` controls for `song_reader` and the note datapath behind it. It consumes `song_reader`'s `song_done` to auto-advance, wrap or stop at the end of the playlist. It sits between the debounced button front end and `song_reader`.

## Interface
- `NUM_SONGS`, default 4: number of songs in ROM, legal range 1..4; song index wraps modulo `NUM_SONGS`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `play_button`  in  1  one-cycle pulse (debounced upstream); toggles play/pause.
- `next_button`  in  1  one-cycle pulse; skip to the next song.
- `loop_en`  in  1  level; at end of the last song, wrap to song 0 and keep playing.
- `song_done`  in  1  from `song_reader`; high for at least one cycle when the current song finishes.
- `play`  out  1  to `song_reader`; high only in state PLAY.
- `song`  out  2  to `song_reader`; current song index.
- `reset_player`  out  1  to `song_reader` and the note datapath; high in states RESET and NEXT.
- `state`  out  2  status encoding: RESET=00, PAUSE=01, PLAY=10, NEXT=11.

## Operation
- Moore FSM with a registered state, a `song` register and a `resume` flag register.
- `play`, `reset_player` and `state` decode directly from the state register; they carry no combinational path from any input.
- RESET:
  - Outputs: `reset_player`=1, `play`=0.
  - `song` is cleared to 0 and `resume` is cleared at the clock edge.
  - All inputs are ignored.
  - Unconditionally goes to PAUSE next cycle.
- PAUSE:
  - Outputs: `play`=0, `reset_player`=0.
  - Priority: `next_button` goes to NEXT with `resume`=0. Otherwise `play_button` goes to PLAY.
  - `song_done` is ignored.
- PLAY:
  - Outputs: `play`=1.
  - Priority 1: `next_button` goes to NEXT with `resume`=1.
  - Priority 2: `song_done`:
    - If `song` != `NUM_SONGS`-1, go to NEXT with `resume`=1.
    - If `song` == `NUM_SONGS`-1 and `loop_en`=1, go to NEXT with `resume`=1; `song` wraps to 0.
    - If `song` == `NUM_SONGS`-1 and `loop_en`=0, go to RESET, which ends in PAUSE with `song`=0.
  - Priority 3: `play_button` goes to PAUSE.
- NEXT:
  - Outputs: `reset_player`=1, `play`=0. Lasts exactly one cycle.
  - At the edge leaving NEXT, `song` becomes (`song`+1) mod `NUM_SONGS`.
  - Next state is PLAY if `resume`=1, else PAUSE.
  - Inputs are ignored.
- Arithmetic:
  - `song` increment is 2-bit; an explicit compare against `NUM_SONGS`-1 forces the wrap to 0.
  - With `NUM_SONGS`=1, NEXT always leaves `song`=0.
- Reset mid-operation: `reset` high in any state forces state=RESET, `song`=0 and `resume`=0 at the next edge. Reset dominates every other input.

## Timing
- Reset values, during and at the first cycle after the reset edge: state=RESET, `play`=0, `song`=0, `reset_player`=1.
- After `reset` deasserts, exactly one more RESET cycle follows, then PAUSE.
- Button latency: a pulse sampled at edge k changes state at edge k; the new outputs are valid from edge k to edge k+1. One cycle from pulse to `play` change.
- NEXT is a one-cycle `reset_player` pulse. During that cycle `song` still shows the old index. The new index and the restored `play` appear together in the following cycle.
- `song_done` held high for several cycles causes exactly one advance. After NEXT, PLAY only re-evaluates `song_done` in the cycle after `play` rises. `song_reader` drops `song_done` while `reset_player` is high, so no double-skip occurs.
- Simultaneous inputs resolve by the per-state priority lists in Operation. Inputs arriving during RESET or NEXT are dropped, not queued.

## Test plan
- Reset:
  - Stimulus: hold `reset` for 3 cycles, then release.
  - Required: `reset_player`=1, `play`=0, `song`=0 throughout reset and for one cycle after; then `state`=01, `reset_player`=0.
- Play/pause:
  - Stimulus: `play_button` pulse in PAUSE, then a second pulse 5 cycles later.
  - Required: `play`=1 from the next cycle; `play`=0 one cycle after the second pulse; `song` unchanged (0).
- Skip while playing:
  - Stimulus: in PLAY with `song`=1, pulse `next_button`.
  - Required: one cycle of `state`=11, `reset_player`=1, `play`=0, `song`=1; then `song`=2, `play`=1, `reset_player`=0.
- End of playlist:
  - Stimulus: in PLAY with `song`=3, `NUM_SONGS`=4, pulse `song_done`.
  - Required with `loop_en`=0: RESET for 1 cycle, then PAUSE with `song`=0, `play`=0.
  - Required with `loop_en`=1: NEXT for 1 cycle, then PLAY with `song`=0.
- Simultaneous buttons:
  - Stimulus: `next_button` and `play_button` pulsed in the same cycle in PAUSE with `song`=0.
  - Required: NEXT, then PAUSE with `song`=1 and `play`=0.
  - Stimulus: `song_done` and `play_button` together in PLAY with `song`=0.
  - Required: NEXT, then PLAY with `song`=1.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle during NEXT, with `song`=2 and `resume`=1.
  - Required: RESET at the next edge with `song`=0; then PAUSE, not PLAY.
